// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: phase detector state encoding, default error width
// and the feedback divider select encodings.
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } pd_state_t;

  localparam int PD_CNT_W = 12;

  localparam logic [1:0] FB_SEL_DIV1 = 2'd0;
  localparam logic [1:0] FB_SEL_DIV2 = 2'd1;
  localparam logic [1:0] FB_SEL_DIV4 = 2'd2;
  localparam logic [1:0] FB_SEL_DIV8 = 2'd3;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector; the
// pulse appears three clk_i edges after the input rises.
module edge_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic sync_d_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      sync_d_q <= 1'b0;
      pulse_o  <= 1'b0;
    end else begin
      meta_q   <= sig_i;
      sync_q   <= meta_q;
      sync_d_q <= sync_q;
      pulse_o  <= sync_q & ~sync_d_q;
    end
  end

endmodule

// File: rtl/phase_detector.sv
// Phase/frequency detector: measures the signed distance in clk_i cycles
// between synchronized reference and selected feedback rising edges.
module phase_detector
  import adpll_pkg::*;
#(
  parameter int CNT_W = PD_CNT_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ref_i,
  input  logic [3:0]       fb_i,
  input  logic [1:0]       fb_sel_i,
  output logic [CNT_W-1:0] err_o,
  output logic             err_valid_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_VAL     = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = MAX_VAL - ONE;

  pd_state_t        state;
  pd_state_t        cur_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] mag;
  logic [1:0]       sel_q;
  logic [1:0]       blank_cnt;
  logic             sel_change;
  logic             fb_mux;
  logic             ref_e;
  logic             fb_raw_e;
  logic             fb_e;

  assign fb_mux = fb_i[fb_sel_i];

  edge_sync u_ref_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (ref_i),
    .pulse_o (ref_e)
  );

  edge_sync u_fb_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (fb_mux),
    .pulse_o (fb_raw_e)
  );

  // A select change aborts the running measurement and keeps mux glitches,
  // which reach fb_raw_e three cycles later, out of the FSM.
  assign sel_change = (fb_sel_i != sel_q);
  assign fb_e       = fb_raw_e & ~sel_change & (blank_cnt == 2'd0);
  assign cur_state  = sel_change ? IDLE : state;
  assign mag        = cnt + ONE;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      err_o       <= '0;
      err_valid_o <= 1'b0;
      sat_o       <= 1'b0;
      sel_q       <= FB_SEL_DIV1;
      blank_cnt   <= 2'd0;
    end else begin
      err_valid_o <= 1'b0;
      sat_o       <= 1'b0;
      sel_q       <= fb_sel_i;
      if (sel_change) begin
        blank_cnt <= 2'd3;
      end else if (blank_cnt != 2'd0) begin
        blank_cnt <= blank_cnt - 2'd1;
      end

      case (cur_state)
        IDLE: begin
          cnt <= '0;
          if (ref_e && fb_e) begin
            err_o       <= '0;
            err_valid_o <= 1'b1;
            state       <= IDLE;
          end else if (ref_e) begin
            state <= REF_LEAD;
          end else if (fb_e) begin
            state <= FB_LEAD;
          end else begin
            state <= IDLE;
          end
        end

        REF_LEAD: begin
          if (fb_e) begin
            err_o       <= mag;
            err_valid_o <= 1'b1;
            cnt         <= '0;
            state       <= ref_e ? REF_LEAD : IDLE;
          end else if (ref_e) begin
            err_o       <= MAX_VAL;
            err_valid_o <= 1'b1;
            sat_o       <= 1'b1;
            cnt         <= '0;
          end else if (cnt == TIMEOUT_CNT) begin
            err_o       <= MAX_VAL;
            err_valid_o <= 1'b1;
            sat_o       <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= mag;
          end
        end

        FB_LEAD: begin
          if (ref_e) begin
            err_o       <= -mag;
            err_valid_o <= 1'b1;
            cnt         <= '0;
            state       <= fb_e ? FB_LEAD : IDLE;
          end else if (fb_e) begin
            err_o       <= -MAX_VAL;
            err_valid_o <= 1'b1;
            sat_o       <= 1'b1;
            cnt         <= '0;
          end else if (cnt == TIMEOUT_CNT) begin
            err_o       <= -MAX_VAL;
            err_valid_o <= 1'b1;
            sat_o       <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= mag;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_detector.sv
// Directed bench for phase_detector: a 12-bit instance for the main cases and
// a 6-bit instance for the timeout case; inputs change 1 time unit after posedge.
module tb_phase_detector;
  import adpll_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ref_i;
  logic [3:0]  fb_i;
  logic [1:0]  fb_sel_i;
  logic [11:0] err;
  logic        err_valid;
  logic        sat;
  logic [5:0]  err6;
  logic        valid6;
  logic        sat6;

  int checks   = 0;
  int failures = 0;
  int strobes;

  phase_detector #(.CNT_W(12)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .ref_i       (ref_i),
    .fb_i        (fb_i),
    .fb_sel_i    (fb_sel_i),
    .err_o       (err),
    .err_valid_o (err_valid),
    .sat_o       (sat)
  );

  phase_detector #(.CNT_W(6)) dut6 (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .ref_i       (ref_i),
    .fb_i        (fb_i),
    .fb_sel_i    (fb_sel_i),
    .err_o       (err6),
    .err_valid_o (valid6),
    .sat_o       (sat6)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] f, input logic [1:0] s, input int cycles);
    ref_i    = r;
    fb_i     = f;
    fb_sel_i = s;
    tick(cycles);
  endtask

  task automatic checkOutput(input string tag, input logic expValid, input logic [11:0] expErr, input logic expSat);
    checks++;
    assert (err_valid === expValid) else begin
      failures++;
      $error("[TB] FAIL %s.valid observed=%0b expected=%0b", tag, err_valid, expValid);
    end
    checks++;
    assert (err === expErr) else begin
      failures++;
      $error("[TB] FAIL %s.err observed=%h expected=%h", tag, err, expErr);
    end
    if (expValid) begin
      checks++;
      assert (sat === expSat) else begin
        failures++;
        $error("[TB] FAIL %s.sat observed=%0b expected=%0b", tag, sat, expSat);
      end
    end
  endtask

  task automatic checkOutput6(input string tag, input logic expValid, input logic [5:0] expErr, input logic expSat);
    checks++;
    assert (valid6 === expValid) else begin
      failures++;
      $error("[TB] FAIL %s.valid6 observed=%0b expected=%0b", tag, valid6, expValid);
    end
    if (expValid) begin
      checks++;
      assert (err6 === expErr) else begin
        failures++;
        $error("[TB] FAIL %s.err6 observed=%h expected=%h", tag, err6, expErr);
      end
      checks++;
      assert (sat6 === expSat) else begin
        failures++;
        $error("[TB] FAIL %s.sat6 observed=%0b expected=%0b", tag, sat6, expSat);
      end
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic countStrobes(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (err_valid === 1'b1) cnt++;
    end
  endtask

  initial begin
    reset_i = 1'b1;
    applyStimulus(1'b0, 4'b0000, FB_SEL_DIV1, 3);
    checkOutput("reset", 1'b0, 12'h000, 1'b0);
    checkValue("reset_state", int'(dut.state), int'(IDLE));
    reset_i = 1'b0;
    tick(5);

    // ref leads fb by 10 cycles on div1
    applyStimulus(1'b1, 4'b0000, FB_SEL_DIV1, 10);
    applyStimulus(1'b1, 4'b0001, FB_SEL_DIV1, 3);
    checkOutput("lead10_pre", 1'b0, 12'h000, 1'b0);
    tick(1);
    checkOutput("lead10", 1'b1, 12'd10, 1'b0);
    tick(1);
    checkOutput("lead10_hold", 1'b0, 12'd10, 1'b0);
    applyStimulus(1'b0, 4'b0000, FB_SEL_DIV1, 6);

    // fb leads ref by 7 cycles on div4
    applyStimulus(1'b0, 4'b0000, FB_SEL_DIV4, 6);
    applyStimulus(1'b0, 4'b0100, FB_SEL_DIV4, 7);
    applyStimulus(1'b1, 4'b0100, FB_SEL_DIV4, 3);
    checkOutput("lag7_pre", 1'b0, 12'd10, 1'b0);
    tick(1);
    checkOutput("lag7", 1'b1, 12'hFF9, 1'b0);
    applyStimulus(1'b0, 4'b0000, FB_SEL_DIV4, 6);

    // reset asserted in REF_LEAD with cnt=20
    applyStimulus(1'b1, 4'b0000, FB_SEL_DIV4, 24);
    checkValue("cnt20_state", int'(dut.state), int'(REF_LEAD));
    checkValue("cnt20", int'(dut.cnt), 20);
    reset_i = 1'b1;
    #1;
    checkOutput("mid_reset", 1'b0, 12'h000, 1'b0);
    checkValue("mid_reset_state", int'(dut.state), int'(IDLE));
    applyStimulus(1'b0, 4'b0000, FB_SEL_DIV4, 2);
    reset_i = 1'b0;
    countStrobes(20, strobes);
    checkValue("post_reset_strobes", strobes, 0);
    checkValue("post_reset_state", int'(dut.state), int'(IDLE));

    // ref and fb from the same net
    applyStimulus(1'b0, 4'b0000, FB_SEL_DIV1, 6);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'b0001, FB_SEL_DIV1, 4);
      checkOutput("same_net", 1'b1, 12'h000, 1'b0);
      applyStimulus(1'b0, 4'b0000, FB_SEL_DIV1, 4);
      checkOutput("same_net_gap", 1'b0, 12'h000, 1'b0);
    end

    // select switch 0->3 five cycles into REF_LEAD, div8 already high
    applyStimulus(1'b1, 4'b1000, FB_SEL_DIV1, 9);
    applyStimulus(1'b1, 4'b1000, FB_SEL_DIV8, 2);
    checkValue("sel_abort_state", int'(dut.state), int'(IDLE));
    countStrobes(10, strobes);
    checkValue("sel_abort_strobes", strobes, 0);
    checkValue("sel_abort_idle", int'(dut.state), int'(IDLE));
    applyStimulus(1'b0, 4'b0000, FB_SEL_DIV8, 6);
    applyStimulus(1'b1, 4'b0000, FB_SEL_DIV8, 4);
    checkOutput("after_sel_open", 1'b0, 12'h000, 1'b0);
    applyStimulus(1'b1, 4'b0000, FB_SEL_DIV8, 1);
    applyStimulus(1'b1, 4'b1000, FB_SEL_DIV8, 3);
    checkOutput("after_sel_pre", 1'b0, 12'h000, 1'b0);
    tick(1);
    checkOutput("after_sel", 1'b1, 12'd5, 1'b0);
    applyStimulus(1'b0, 4'b0000, FB_SEL_DIV8, 4);

    // timeout on the 6-bit instance, cycle slip on the 12-bit one
    reset_i = 1'b1;
    applyStimulus(1'b0, 4'b0000, FB_SEL_DIV1, 2);
    reset_i = 1'b0;
    tick(5);
    applyStimulus(1'b1, 4'b0000, FB_SEL_DIV1, 34);
    checkOutput6("timeout_pre", 1'b0, 6'h00, 1'b0);
    tick(1);
    checkOutput6("timeout", 1'b1, 6'd31, 1'b1);
    checkOutput("no_slip_yet", 1'b0, 12'h000, 1'b0);
    tick(1);
    checkOutput6("timeout_once", 1'b0, 6'h00, 1'b0);
    applyStimulus(1'b1, 4'b0000, FB_SEL_DIV1, 4);
    applyStimulus(1'b0, 4'b0000, FB_SEL_DIV1, 10);
    applyStimulus(1'b1, 4'b0000, FB_SEL_DIV1, 4);
    checkOutput("slip", 1'b1, 12'h7FF, 1'b1);
    checkOutput6("reopen", 1'b0, 6'h00, 1'b0);
    checkValue("reopen_state6", int'(dut6.state), int'(REF_LEAD));
    tick(31);
    checkOutput6("timeout2", 1'b1, 6'd31, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
